// File: rtl/fetch_unit_pkg.sv
// Shared types and defaults for the instruction fetch unit.
// No logic of its own; consumed by the interface and the top.
// Backpressure: n/a.
package fetch_unit_pkg;

    // Fetch controller states
    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_HOLD  = 2'd1,
        ST_DRAIN = 2'd2
    } fetch_state_e;

    // Reset PC doubles as the exception vector
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_NOP_WORD = 32'h0000_0000;

    // Force a byte address onto a word boundary
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & ~32'h0000_0003;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Bundles the next-PC, instruction-memory and decode-side signals of the fetch unit.
// Latency: n/a (wires only).
// Backpressure: imem_req/imem_ack request-hold, inst_valid/inst_ready to decode.
interface fetch_unit_if;

    // Next-PC / redirect side
    logic [31:0] nextpc;
    logic        flush;
    logic [31:0] flush_pc;
    logic [31:0] pc;

    // Instruction memory side
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        imem_err;

    // Decode side
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        inst_fault;

    // Fetch unit view
    modport master (
        input  nextpc, flush, flush_pc,
        output pc,
        output imem_req, imem_addr,
        input  imem_ack, imem_rdata, imem_err,
        output inst_valid, inst, inst_pc, inst_fault,
        input  inst_ready
    );

    // Environment view (next-PC logic, memory, decode)
    modport slave (
        output nextpc, flush, flush_pc,
        input  pc,
        input  imem_req, imem_addr,
        output imem_ack, imem_rdata, imem_err,
        input  inst_valid, inst, inst_pc, inst_fault,
        output inst_ready
    );

endinterface

// File: rtl/fetch_unit.sv
// Owns the fetch PC, issues one instruction-memory request at a time, buffers the word for decode.
// Latency: imem_ack to inst_valid is 1 cycle; zero-wait throughput is 1 instruction per 2 cycles.
// Backpressure: holds the buffered word while inst_ready=0; imem_req stays up with a stable address until imem_ack.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
    parameter logic [31:0] NOP_WORD = DEFAULT_NOP_WORD
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q, pc_d;
    logic [31:0]  drain_addr_q, drain_addr_d;
    logic         inst_valid_q, inst_valid_d;
    logic [31:0]  inst_q, inst_d;
    logic [31:0]  inst_pc_q, inst_pc_d;
    logic         inst_fault_q, inst_fault_d;

    // A response is only taken from memory while a request is on the bus
    logic         ack_fetch;
    logic         consume;

    assign ack_fetch = (state_q == ST_FETCH) && bus.imem_ack;
    assign consume   = (state_q == ST_HOLD) && bus.inst_ready;

    // State and datapath registers; reset wins over any in-flight ack
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_FETCH;
            pc_q         <= word_align(RESET_PC);
            drain_addr_q <= '0;
            inst_valid_q <= 1'b0;
            inst_q       <= NOP_WORD;
            inst_pc_q    <= '0;
            inst_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drain_addr_q <= drain_addr_d;
            inst_valid_q <= inst_valid_d;
            inst_q       <= inst_d;
            inst_pc_q    <= inst_pc_d;
            inst_fault_q <= inst_fault_d;
        end
    end

    // Next-state: flush overrides everything, but a request already on the bus must be drained
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_FETCH: begin
                if (bus.flush) begin
                    // With an ack this cycle the bus is already free, so just refetch
                    state_d = bus.imem_ack ? ST_FETCH : ST_DRAIN;
                end else if (bus.imem_ack) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (bus.flush || bus.inst_ready) begin
                    state_d = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // Further flushes only move the target; the aborted request still has to complete
                if (bus.imem_ack) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_FETCH;
        endcase
    end

    // Datapath updates: PC, drain address and the decode buffer
    always_comb begin
        pc_d         = pc_q;
        drain_addr_d = drain_addr_q;
        inst_valid_d = inst_valid_q;
        inst_d       = inst_q;
        inst_pc_d    = inst_pc_q;
        inst_fault_d = inst_fault_q;

        if (bus.flush) begin
            pc_d         = word_align(bus.flush_pc);
            inst_valid_d = 1'b0;
            // Remember the address still on the bus so it can be held until its ack
            if ((state_q == ST_FETCH) && !bus.imem_ack) begin
                drain_addr_d = pc_q;
            end
        end else if (ack_fetch) begin
            inst_d       = bus.imem_err ? NOP_WORD : bus.imem_rdata;
            inst_fault_d = bus.imem_err;
            inst_pc_d    = pc_q;
            inst_valid_d = 1'b1;
        end else if (consume) begin
            pc_d         = word_align(bus.nextpc);
            inst_valid_d = 1'b0;
        end
    end

    // Outputs: request is live in FETCH and DRAIN, and forced low during reset
    always_comb begin
        bus.imem_req   = !rst && (state_q != ST_HOLD);
        bus.imem_addr  = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;
        bus.pc         = pc_q;
        bus.inst_valid = inst_valid_q;
        bus.inst       = inst_q;
        bus.inst_pc    = inst_pc_q;
        bus.inst_fault = inst_fault_q;
    end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Owns the architectural fetch PC and drives the instruction-memory request interface.
- Each fetched word is delivered to decode over a valid/ready handshake.
- Next-PC logic consumes `pc`/`inst_pc` and returns `nextpc` plus a `flush` redirect for exception and eret.
- This block is the other end of that loop: it turns a computed next PC into an actual fetch transaction.

Parameters:
- RESET_PC, 32'h0000_0000, fetch address after reset; matches the exception vector.
- NOP_WORD, 32'h0000_0000, value presented on `inst` for a faulted fetch.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- nextpc  in  32  PC to fetch after the current instruction is consumed; bits [1:0] ignored.
- flush  in  1  redirect request; highest priority.
- flush_pc  in  32  redirect target; bits [1:0] ignored.
- pc  out  32  current fetch PC register; bits [1:0] always 0.
- imem_req  out  1  memory request.
- imem_addr  out  32  request address; equals the address latched for the outstanding request.
- imem_ack  in  1  response strobe; may arrive in the same cycle as `imem_req`.
- imem_rdata  in  32  instruction word; valid with `imem_ack`.
- imem_err  in  1  bus error; valid with `imem_ack`.
- inst_valid  out  1  buffered instruction available to decode.
- inst_ready  in  1  decode consumes the instruction this cycle.
- inst  out  32  buffered instruction word.
- inst_pc  out  32  address of `inst`.
- inst_fault  out  1  `inst` came from an errored fetch.

Behaviour:
- States: FETCH, HOLD, DRAIN (2-bit encoding).
- Reset (rst=1 at an edge), takes effect even mid-transaction:
  - state=FETCH, pc=RESET_PC.
  - inst_valid=0, inst=NOP_WORD, inst_pc=0, inst_fault=0.
  - imem_req is combinationally 0 while rst=1.
  - A pending ack is ignored.
- Memory protocol:
  - imem_req stays high with a stable imem_addr until imem_ack.
  - One outstanding request maximum.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On ack with flush=0: inst<=err?NOP_WORD:imem_rdata, inst_fault<=err, inst_pc<=pc, inst_valid<=1, go to HOLD.
  - Latency from ack to inst_valid is 1 cycle.
- HOLD:
  - imem_req=0, inst_valid=1, outputs stable.
  - On inst_ready with flush=0: pc<={nextpc[31:2],2'b00}, inst_valid<=0, go to FETCH.
  - Zero-wait throughput is therefore 1 instruction per 2 cycles.
- DRAIN:
  - imem_req=1, imem_addr=the aborted address (held in a separate drain-address register).
  - On ack: discard data and error, go to FETCH. pc already holds the redirect target.
- Flush, which overrides all other transitions, always sets pc<={flush_pc[31:2],2'b00} and inst_valid<=0:
  - FETCH, no ack: latch old pc into the drain-address register, go to DRAIN.
  - FETCH with ack in the same cycle: discard the response, stay in FETCH.
  - HOLD: the buffered instruction is dropped even if inst_ready=1, and nextpc is ignored; go to FETCH.
  - DRAIN, no ack: latest flush_pc wins; stay in DRAIN.
  - DRAIN with ack: go to FETCH.
- inst_ready while inst_valid=0 has no effect.
- Arithmetic: no adders inside; PC wrap-around is the caller's concern. Low 2 bits are forced to 0 on every pc write.
- Error fetch: delivered as an ordinary instruction with inst_fault=1. The block does not redirect itself.

Decomposition:
- Shared package holds:
  - fetch state encoding (FETCH=0, HOLD=1, DRAIN=2).
  - RESET_PC and NOP_WORD defaults.
  - word-align helper (clear bits [1:0]).
- No sub-module: one FSM plus registers (pc, drain address, inst buffer).

Test Plan:
- Reset then zero-wait memory (ack same cycle as req, rdata=32'h2408_0001) -> imem_addr=0x0; inst_valid rises next cycle with inst=32'h2408_0001, inst_pc=0. With inst_ready=1 and nextpc=0x4, the next request is to 0x4 one cycle later.
- Decode stall: inst_ready=0 for 5 cycles in HOLD -> imem_req=0, inst/inst_pc stable. Consume with nextpc=0x0000_0103 -> pc=0x0000_0100.
- Flush while a 3-wait-state request to 0x8 is pending, flush_pc=0x80 -> DRAIN, imem_addr stays 0x8 until ack, data discarded. Next request is to 0x80; the 0x8 data never appears on inst.
- Flush and ack in the same FETCH cycle (flush_pc=0x40) -> inst_valid stays 0; next cycle imem_addr=0x40.
- Flush and inst_ready in the same HOLD cycle (nextpc=0x10, flush_pc=0x200) -> pc=0x200, instruction dropped.
- imem_err on ack -> inst=NOP_WORD, inst_fault=1. Reset asserted in DRAIN -> next cycle pc=RESET_PC, FETCH, inst_valid=0.
